// File: rtl/point_spawner.sv
// Food-point spawner: keeps up to NUM_POINTS live points on the map, drawing
// candidate tiles from a seeded 16-bit LFSR and rejecting occupied or duplicate tiles.
module point_spawner #(
    parameter int          MAP_WIDTH  = 32,
    parameter int          MAP_HEIGHT = 24,
    parameter int          NUM_POINTS = 2,
    parameter int          MAX_TRIES  = 8,
    parameter logic [15:0] LFSR_RESET = 16'hACE1,
    localparam int         XW         = $clog2(MAP_WIDTH),
    localparam int         YW         = $clog2(MAP_HEIGHT)
) (
    input  logic                       clk_75,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       seed_load,
    input  logic [15:0]                seed_in,
    input  logic [NUM_POINTS-1:0]      consume,
    output logic                       q_valid,
    output logic [XW-1:0]              q_x,
    output logic [YW-1:0]              q_y,
    input  logic                       q_occupied,
    output logic [NUM_POINTS*XW-1:0]   pt_x,
    output logic [NUM_POINTS*YW-1:0]   pt_y,
    output logic [NUM_POINTS-1:0]      pt_valid,
    output logic                       busy,
    output logic                       fail
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int SW = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        QUERY = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [15:0]               lfsr_q, lfsr_d;
    logic [SW-1:0]             sel_q, sel_d;
    logic [TW-1:0]             tries_q, tries_d;
    logic [XW-1:0]             cx_q, cx_d;
    logic [YW-1:0]             cy_q, cy_d;
    logic [NUM_POINTS*XW-1:0]  ptX_q, ptX_d;
    logic [NUM_POINTS*YW-1:0]  ptY_q, ptY_d;
    logic [NUM_POINTS-1:0]     ptValid_q, ptValid_d;
    logic                      fail_q, fail_d;

    logic [15:0]   lfsrStep;
    logic [XW-1:0] rx, candX;
    logic [YW-1:0] ry, candY;
    logic [SW-1:0] freeSel;
    logic          anyFree;
    logic          dupHit;

    // Candidate comes from the post-step value so DRAW can register it directly.
    always_comb begin
        lfsrStep = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        rx       = lfsrStep[XW-1:0];
        ry       = lfsrStep[15 -: YW];
        candX    = (rx >= XW'(MAP_WIDTH - 2))  ? XW'(rx - XW'(MAP_WIDTH - 2))  : rx;
        candY    = (ry >= YW'(MAP_HEIGHT - 2)) ? YW'(ry - YW'(MAP_HEIGHT - 2)) : ry;
        candX    = XW'(candX + XW'(1));
        candY    = YW'(candY + YW'(1));
    end

    always_comb begin
        freeSel = '0;
        anyFree = 1'b0;
        for (int i = NUM_POINTS - 1; i >= 0; i--) begin
            if (!ptValid_q[i]) begin
                freeSel = SW'(i);
                anyFree = 1'b1;
            end
        end
    end

    always_comb begin
        dupHit = 1'b0;
        for (int i = 0; i < NUM_POINTS; i++) begin
            if ((SW'(i) != sel_q) && ptValid_q[i] &&
                (ptX_q[i*XW +: XW] == cx_q) && (ptY_q[i*YW +: YW] == cy_q)) begin
                dupHit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        sel_d     = sel_q;
        tries_d   = tries_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        ptX_d     = ptX_q;
        ptY_d     = ptY_q;
        ptValid_d = ptValid_q & ~consume;
        fail_d    = 1'b0;

        if (seed_load) begin
            lfsr_d    = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
            ptValid_d = '0;
            state_d   = IDLE;
        end else if (!enable && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && anyFree) begin
                        sel_d   = freeSel;
                        tries_d = '0;
                        state_d = DRAW;
                    end
                end
                DRAW: begin
                    lfsr_d  = lfsrStep;
                    cx_d    = candX;
                    cy_d    = candY;
                    tries_d = TW'(tries_q + TW'(1));
                    state_d = QUERY;
                end
                QUERY: begin
                    state_d = CHECK;
                end
                CHECK: begin
                    if (!q_occupied && !dupHit) begin
                        for (int i = 0; i < NUM_POINTS; i++) begin
                            if (SW'(i) == sel_q) begin
                                ptX_d[i*XW +: XW] = cx_q;
                                ptY_d[i*YW +: YW] = cy_q;
                                ptValid_d[i]      = 1'b1;
                            end
                        end
                        state_d = IDLE;
                    end else if (tries_q < TW'(MAX_TRIES)) begin
                        state_d = DRAW;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_75 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_RESET;
            sel_q     <= '0;
            tries_q   <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            ptX_q     <= '0;
            ptY_q     <= '0;
            ptValid_q <= '0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            sel_q     <= sel_d;
            tries_q   <= tries_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            ptX_q     <= ptX_d;
            ptY_q     <= ptY_d;
            ptValid_q <= ptValid_d;
            fail_q    <= fail_d;
        end
    end

    // Query coordinates are held at zero outside the strobe cycle.
    assign q_valid  = (state_q == QUERY);
    assign q_x      = q_valid ? cx_q : '0;
    assign q_y      = q_valid ? cy_q : '0;
    assign pt_x     = ptX_q;
    assign pt_y     = ptY_q;
    assign pt_valid = ptValid_q;
    assign busy     = (state_q != IDLE);
    assign fail     = fail_q;

endmodule

// File: tb/tb_point_spawner.sv
// Directed self-checking bench for point_spawner with a small occupancy responder.
module tb_point_spawner;

    logic        clk_75 = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic [1:0]  consume = 2'b00;
    logic        q_valid;
    logic [4:0]  q_x;
    logic [4:0]  q_y;
    logic        q_occupied = 1'b0;
    logic [9:0]  pt_x;
    logic [9:0]  pt_y;
    logic [1:0]  pt_valid;
    logic        busy;
    logic        fail;

    int compared = 0;
    int mismatched = 0;

    logic occAll = 1'b0;
    logic occFirst = 1'b0;
    int   qCount = 0;
    int   occBase = 0;

    point_spawner dut (
        .clk_75(clk_75), .rst_n(rst_n), .enable(enable), .seed_load(seed_load),
        .seed_in(seed_in), .consume(consume), .q_valid(q_valid), .q_x(q_x), .q_y(q_y),
        .q_occupied(q_occupied), .pt_x(pt_x), .pt_y(pt_y), .pt_valid(pt_valid),
        .busy(busy), .fail(fail)
    );

    always #5 clk_75 = ~clk_75;

    // Map model: answers each query on the following cycle.
    always @(posedge clk_75) begin
        if (q_valid) begin
            q_occupied <= occAll || (occFirst && (qCount == occBase));
            qCount     <= qCount + 1;
        end
    end

    function automatic logic [4:0] slotX(input int i);
        return pt_x[i*5 +: 5];
    endfunction

    function automatic logic [4:0] slotY(input int i);
        return pt_y[i*5 +: 5];
    endfunction

    task automatic step();
        @(posedge clk_75);
        #1;
    endtask

    task automatic loadSeed(input logic [15:0] s);
        enable    = 1'b0;
        seed_in   = s;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
    endtask

    task automatic test_reset();
        int activity;
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        compared++; if ({q_valid, q_x, q_y, pt_x, pt_y, pt_valid, busy, fail} !== 24'h0) begin mismatched++; $display("[TB] FAIL reset_outputs: got %h expected 0", {q_valid, q_x, q_y, pt_x, pt_y, pt_valid, busy, fail}); end
        step();
        rst_n = 1'b1;
        activity = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy || q_valid) activity++;
        end
        compared++; if (activity !== 0) begin mismatched++; $display("[TB] FAIL idle_after_reset: got %0d active cycles expected 0", activity); end
    endtask

    task automatic test_first_fill();
        loadSeed(16'h0001);
        enable = 1'b1;
        step();
        compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_busy: got %b expected 1", busy); end
        step();
        compared++; if ({q_valid, q_x, q_y} !== {1'b1, 5'd3, 5'd1}) begin mismatched++; $display("[TB] FAIL fill_query0: got %b/%0d/%0d expected 1/3/1", q_valid, q_x, q_y); end
        step();
        compared++; if (pt_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL fill_early: got %b expected 00", pt_valid); end
        step();
        compared++; if ({pt_valid, slotX(0), slotY(0), busy} !== {2'b01, 5'd3, 5'd1, 1'b0}) begin mismatched++; $display("[TB] FAIL fill_slot0: got v=%b (%0d,%0d) busy=%b expected v=01 (3,1) busy=0", pt_valid, slotX(0), slotY(0), busy); end
        step();
        step();
        compared++; if ({q_valid, q_x, q_y} !== {1'b1, 5'd5, 5'd1}) begin mismatched++; $display("[TB] FAIL fill_query1: got %b/%0d/%0d expected 1/5/1", q_valid, q_x, q_y); end
        step();
        compared++; if (pt_valid !== 2'b01) begin mismatched++; $display("[TB] FAIL fill_slot1_early: got %b expected 01", pt_valid); end
        step();
        compared++; if ({pt_valid, slotX(1), slotY(1)} !== {2'b11, 5'd5, 5'd1}) begin mismatched++; $display("[TB] FAIL fill_slot1: got v=%b (%0d,%0d) expected v=11 (5,1)", pt_valid, slotX(1), slotY(1)); end
        step();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_settled: got busy=%b expected 0", busy); end
    endtask

    task automatic test_consume();
        consume = 2'b01;
        step();
        consume = 2'b00;
        compared++; if ({pt_valid, slotX(0), busy} !== {2'b10, 5'd3, 1'b0}) begin mismatched++; $display("[TB] FAIL consume_clear: got v=%b x=%0d busy=%b expected v=10 x=3 busy=0", pt_valid, slotX(0), busy); end
        step();
        compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL consume_refill_start: got %b expected 1", busy); end
        step();
        step();
        compared++; if (pt_valid !== 2'b10) begin mismatched++; $display("[TB] FAIL consume_refill_early: got %b expected 10", pt_valid); end
        step();
        compared++; if ({pt_valid, slotX(0), slotY(0)} !== {2'b11, 5'd9, 5'd1}) begin mismatched++; $display("[TB] FAIL consume_refill: got v=%b (%0d,%0d) expected v=11 (9,1)", pt_valid, slotX(0), slotY(0)); end
    endtask

    task automatic test_wall_avoid();
        loadSeed(16'h000F);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) step();
        compared++; if ({pt_valid, slotX(0), slotY(0)} !== {2'b01, 5'd1, 5'd1}) begin mismatched++; $display("[TB] FAIL wall_slot0: got v=%b (%0d,%0d) expected v=01 (1,1)", pt_valid, slotX(0), slotY(0)); end
        for (int i = 0; i < 4; i++) step();
        compared++; if ({pt_valid, slotX(1), slotY(1)} !== {2'b11, 5'd29, 5'd1}) begin mismatched++; $display("[TB] FAIL wall_slot1: got v=%b (%0d,%0d) expected v=11 (29,1)", pt_valid, slotX(1), slotY(1)); end
    endtask

    task automatic test_occupied_retry();
        loadSeed(16'h0001);
        occBase  = qCount;
        occFirst = 1'b1;
        enable   = 1'b1;
        for (int i = 0; i < 6; i++) step();
        compared++; if (pt_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL retry_early: got %b expected 00", pt_valid); end
        step();
        compared++; if ({pt_valid, slotX(0), slotY(0)} !== {2'b01, 5'd5, 5'd1}) begin mismatched++; $display("[TB] FAIL retry_slot0: got v=%b (%0d,%0d) expected v=01 (5,1)", pt_valid, slotX(0), slotY(0)); end
        occFirst = 1'b0;
    endtask

    task automatic test_exhaustion();
        int pulses;
        bit seen;
        loadSeed(16'h0001);
        occAll = 1'b1;
        enable = 1'b1;
        pulses = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (q_valid) pulses++;
            if (fail) begin
                seen = 1'b1;
                compared++; if ({busy, pt_valid} !== 3'b000) begin mismatched++; $display("[TB] FAIL exhaust_at_fail: got busy=%b v=%b expected 0/00", busy, pt_valid); end
            end
        end
        compared++; if (!seen) begin mismatched++; $display("[TB] FAIL exhaust_timeout: got no fail pulse expected one"); end
        compared++; if (pulses !== 8) begin mismatched++; $display("[TB] FAIL exhaust_pulses: got %0d expected 8", pulses); end
        step();
        compared++; if ({busy, fail, pt_valid} !== 4'b1000) begin mismatched++; $display("[TB] FAIL exhaust_restart: got busy=%b fail=%b v=%b expected 1/0/00", busy, fail, pt_valid); end
        occAll = 1'b0;
        enable = 1'b0;
        step();
    endtask

    task automatic test_enable_abort();
        loadSeed(16'h0001);
        enable = 1'b1;
        step();
        step();
        compared++; if (q_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_in_query: got %b expected 1", q_valid); end
        enable = 1'b0;
        step();
        compared++; if ({busy, pt_valid} !== 3'b000) begin mismatched++; $display("[TB] FAIL abort_idle: got busy=%b v=%b expected 0/00", busy, pt_valid); end
        step();
        enable = 1'b1;
        step();
        step();
        compared++; if ({q_valid, q_x, q_y} !== {1'b1, 5'd5, 5'd1}) begin mismatched++; $display("[TB] FAIL abort_lfsr_kept: got %b/%0d/%0d expected 1/5/1", q_valid, q_x, q_y); end
        step();
        step();
        compared++; if ({pt_valid, slotX(0), slotY(0)} !== {2'b01, 5'd5, 5'd1}) begin mismatched++; $display("[TB] FAIL abort_refill: got v=%b (%0d,%0d) expected v=01 (5,1)", pt_valid, slotX(0), slotY(0)); end
    endtask

    task automatic test_zero_seed_abort();
        loadSeed(16'h1234);
        enable = 1'b1;
        step();
        step();
        compared++; if (q_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL zseed_in_query: got %b expected 1", q_valid); end
        seed_in   = 16'h0000;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        compared++; if ({busy, q_valid, pt_valid} !== 4'b0000) begin mismatched++; $display("[TB] FAIL zseed_idle: got busy=%b qv=%b v=%b expected 0/0/00", busy, q_valid, pt_valid); end
        step();
        step();
        compared++; if ({q_valid, q_x, q_y} !== {1'b1, 5'd3, 5'd1}) begin mismatched++; $display("[TB] FAIL zseed_query: got %b/%0d/%0d expected 1/3/1", q_valid, q_x, q_y); end
        step();
        step();
        compared++; if ({pt_valid, slotX(0), slotY(0)} !== {2'b01, 5'd3, 5'd1}) begin mismatched++; $display("[TB] FAIL zseed_slot0: got v=%b (%0d,%0d) expected v=01 (3,1)", pt_valid, slotX(0), slotY(0)); end
        for (int i = 0; i < 4; i++) step();
        compared++; if ({pt_valid, slotX(1), slotY(1)} !== {2'b11, 5'd5, 5'd1}) begin mismatched++; $display("[TB] FAIL zseed_slot1: got v=%b (%0d,%0d) expected v=11 (5,1)", pt_valid, slotX(1), slotY(1)); end
    endtask

    initial begin
        test_reset();
        test_first_fill();
        test_consume();
        test_wall_avoid();
        test_occupied_retry();
        test_exhaustion();
        test_enable_abort();
        test_zero_seed_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/point_spawner.md
# point_spawner

Parametrised food-point generator for the snake game core. It keeps up to NUM_POINTS food points live on the map. Whenever a slot is empty, it draws candidate tiles from a deterministic 16-bit LFSR and rejects candidates that are occupied (queried from the map) or that duplicate another live point. It sits between the seed exchange logic (UART seed sharing) and the map update stage. Given the same seed, two consoles produce identical point sequences.

## Interface

Parameters:
- MAP_WIDTH, 32: map columns, including the border walls.
- MAP_HEIGHT, 24: map rows, including the border walls.
- NUM_POINTS, 2: number of simultaneous point slots (1..8).
- MAX_TRIES, 8: candidate draws per refill attempt before giving up.
- LFSR_RESET, 16'hACE1: LFSR value at reset.
- Derived: XW = $clog2(MAP_WIDTH), YW = $clog2(MAP_HEIGHT).
- Constraints: MAP_WIDTH-2 >= 2^(XW-1) and MAP_HEIGHT-2 >= 2^(YW-1).

Ports:
- clk_75, in, 1: system clock. One clock domain only.
- rst_n, in, 1: reset, asynchronous and active-low.
- enable, in, 1: game running. Refills start only while this is high.
- seed_load, in, 1: synchronous load of seed_in.
- seed_in, in, 16: seed value (local or remote).
- consume, in, NUM_POINTS: per-slot pulse meaning the point was eaten.
- q_valid, out, 1: occupancy query strobe.
- q_x / q_y, out, XW / YW: tile being queried.
- q_occupied, in, 1: tile is non-EMPTY. Valid on the cycle after q_valid.
- pt_x / pt_y, out, NUM_POINTS*XW / NUM_POINTS*YW: slot i is at bits [i*XW +: XW] and [i*YW +: YW].
- pt_valid, out, NUM_POINTS: slot i holds a live point.
- busy, out, 1: FSM is not in IDLE.
- fail, out, 1: one-cycle pulse when a refill exhausts MAX_TRIES.

## Operation

LFSR:
- 16-bit Fibonacci: next = {s[14:0], s[15]^s[13]^s[12]^s[10]}.
- It advances only in DRAW, never free-running.
- seed_load loads seed_in. A seed of 0 is replaced with 16'h0001.

Candidate (computed from the post-step LFSR value):
- rx = s[XW-1:0]. cx = 1 + (rx >= MAP_WIDTH-2 ? rx-(MAP_WIDTH-2) : rx).
- ry = s[15 -: YW]. cy = 1 + (ry >= MAP_HEIGHT-2 ? ry-(MAP_HEIGHT-2) : ry).
- The result always lies in the interior: 1..W-2 and 1..H-2.

FSM states:
- IDLE: if enable and any pt_valid bit is 0, select the lowest-index empty slot, clear tries, go to DRAW.
- DRAW: step the LFSR, register cx/cy, tries++, go to QUERY.
- QUERY: q_valid=1, q_x=cx, q_y=cy. Go to CHECK.
- CHECK: the candidate is rejected if q_occupied=1 or (cx,cy) equals any other slot that has pt_valid=1.
  - Accepted: write pt_x/pt_y[sel], set pt_valid[sel], go to IDLE.
  - Rejected and tries<MAX_TRIES: go to DRAW.
  - Rejected and tries==MAX_TRIES: fail=1 for one cycle, go to IDLE. The slot stays empty and is retried from IDLE with the advanced LFSR.

consume and other inputs:
- consume[i] clears pt_valid[i]; pt_x/pt_y keep their old value.
- consume on an already-empty slot is ignored.
- consume on other slots during a refill is honoured. The duplicate check uses pt_valid as seen in CHECK.

Priority, highest first:
- seed_load: loads the LFSR, clears all pt_valid, forces IDLE. It overrides consume and any in-flight refill.
- enable low outside IDLE: aborts to IDLE on the next edge. The slot stays empty and the LFSR is retained.
- Normal FSM operation.

## Timing

Reset (async assert, sync release) values:
- LFSR=LFSR_RESET, state=IDLE.
- pt_valid=0, pt_x=0, pt_y=0.
- q_valid=0, q_x=0, q_y=0.
- busy=0, fail=0.

Refill latency, with consume[i] sampled at edge k:
- pt_valid[i] is low after edge k.
- IDLE→DRAW at k+1, DRAW→QUERY at k+2, QUERY→CHECK at k+3.
- On first-try success, pt_valid[i] is high after edge k+4.
- Each rejected try adds 3 cycles.

Other timing:
- q_valid is high for exactly one cycle per try. Back-to-back tries are spaced 3 cycles apart.
- busy is high from the edge leaving IDLE until the edge returning to IDLE.
- With several slots empty, they are filled sequentially in ascending index order. There is no gap beyond the one IDLE cycle between refills.

## Test plan

- Reset values: assert rst_n=0 mid-cycle → all outputs are 0 immediately. After release with enable=0, busy stays 0 and q_valid never pulses.
- First fill: seed_load with seed_in=16'h0001, then enable=1, q_occupied=0, NUM_POINTS=2 → slot0=(3,1) and slot1=(5,1). Slot0 goes valid 4 cycles after enable is sampled, slot1 4 cycles later.
- Wall avoidance: seed_in=16'h000F → LFSR=16'h001E, rx=30 wraps to 0 → slot0=(1,1).
- Occupancy retry: seed 16'h0001, q_occupied=1 on the first query only → (3,1) rejected; slot0=(5,1) valid 7 cycles after the IDLE exit.
- Exhaustion: q_occupied held at 1, MAX_TRIES=8 → 8 q_valid pulses, then fail for one cycle, busy drops. A new refill starts the next cycle and pt_valid stays 0.
- Abort and zero seed: seed_load with seed_in=0 during QUERY → LFSR=16'h0001, all pt_valid=0, state IDLE next cycle. The subsequent fill matches the first-fill scenario.
